pc_int_ctrl: RTL and testbench

Parametrised program-counter and interrupt controller for the CPU fetch stage, successor to the fixed four-plus-four interrupt PC unit. It advances, jumps or vectors the PC once per instruction on the writeBack rising edge. It latches rising edges on NUM_INT interrupt lines with a per-source mask and fixed priority. It reports the serviced source ID, and optionally supports priority-preemptive nesting through a backup stack.

---
 rtl/pc_int_pkg.sv | 25 ++
 rtl/int_edge_latch.sv | 52 +++++
 rtl/pc_int_ctrl.sv | 143 ++++++++++++++
 tb/tb_pc_int_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_int_pkg.sv
`default_nettype none
// ============================================================================
// pc_int_pkg : shared defaults, ID width helper and backup stack entry type
// Rev 1.0
// ============================================================================
package pc_int_pkg;

  localparam int                    PC_W_DEF     = 27;
  localparam logic [PC_W_DEF-1:0]   PC_START_DEF = 27'hC02522;

  // Stack entries are sized for the widest supported PC and 32 sources.
  localparam int STK_PC_W = 32;
  localparam int STK_ID_W = 5;

  typedef struct packed {
    logic [STK_PC_W-1:0] pc;
    logic [STK_ID_W-1:0] id;
  } stack_entry_t;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_edge_latch.sv
`default_nettype none
// ============================================================================
// int_edge_latch : per-source rising-edge capture, pending set/clear, mask reg
// Rev 1.0
// ============================================================================
module int_edge_latch
  import pc_int_pkg::*;
#(
  parameter int NUM_INT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_INT-1:0] int_in,
  input  logic               mask_we,
  input  logic [NUM_INT-1:0] mask_wdata,
  input  logic [NUM_INT-1:0] clr,
  output logic [NUM_INT-1:0] pending,
  output logic [NUM_INT-1:0] mask
);

  logic [NUM_INT-1:0] samp_q, samp_d;
  logic [NUM_INT-1:0] prev_q, prev_d;
  logic [NUM_INT-1:0] pend_q, pend_d;
  logic [NUM_INT-1:0] mask_q, mask_d;

  always_comb begin
    samp_d = int_in;
    prev_d = samp_q;
    // A fresh edge beats a same-cycle service clear.
    pend_d = (pend_q & ~clr) | (samp_q & ~prev_q);
    mask_d = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      samp_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '1;
    end else begin
      samp_q <= samp_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  assign pending = pend_q;
  assign mask    = mask_q;

endmodule
`default_nettype wire

// File: rtl/pc_int_ctrl.sv
`default_nettype none
// ============================================================================
// pc_int_ctrl : PC stepping with fixed-priority interrupt vectoring
// Optional priority-preemptive nesting via macro PC_INT_NEST_EN.  Rev 1.0
// ============================================================================
module pc_int_ctrl
  import pc_int_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] PC_START   = PC_W'(PC_START_DEF),
  parameter int              NUM_INT    = 8,
  parameter int              VEC_BASE   = 1,
  parameter int              NEST_DEPTH = 4,
  parameter int              ID_W       = id_width(NUM_INT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               writeBack,
  input  logic               jump,
  input  logic               offset,
  input  logic [PC_W-1:0]    jump_addr,
  input  logic               reti,
  input  logic [NUM_INT-1:0] int_in,
  input  logic               mask_we,
  input  logic [NUM_INT-1:0] mask_wdata,
  output logic [PC_W-1:0]    pc_out,
  output logic [ID_W-1:0]    int_id,
  output logic               int_active,
  output logic [NUM_INT-1:0] pending
);

`ifdef PC_INT_NEST_EN
  localparam int DEPTH = NEST_DEPTH;
`else
  // Without nesting a single backup slot suffices whatever NEST_DEPTH says.
  localparam int DEPTH = (NEST_DEPTH > 0) ? 1 : 1;
`endif
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;
  logic               int_active_q, int_active_d;
  logic               wb_q, wb_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  stack_entry_t       stack_q [DEPTH];
  stack_entry_t       stack_d [DEPTH];

  logic [NUM_INT-1:0] mask, elig, clr;
  logic [ID_W-1:0]    win;
  logic               win_vld, gate;
  logic [IDX_W-1:0]   push_idx, pop_idx;
  logic [PC_W-1:0]    ret_pc;
  stack_entry_t       top;

  int_edge_latch #(.NUM_INT(NUM_INT)) u_edge (
    .clk        (clk),
    .reset      (reset),
    .int_in     (int_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .clr        (clr),
    .pending    (pending),
    .mask       (mask)
  );

  always_comb begin
    elig    = pending & mask & {NUM_INT{pc_q < PC_START}};
    win     = '0;
    win_vld = 1'b0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win     = ID_W'(i);
        win_vld = 1'b1;
      end
    end
  end

`ifdef PC_INT_NEST_EN
  assign gate = (sp_q == '0) || ((win < int_id_q) && (sp_q != SP_W'(DEPTH)));
`else
  assign gate = !int_active_q;
`endif

  // Index arithmetic wraps in IDX_W bits, so sp == DEPTH still pops the top slot.
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = push_idx - IDX_W'(1);
  assign top      = stack_q[pop_idx];
  assign ret_pc   = jump ? (offset ? pc_q + jump_addr : jump_addr) : pc_q + PC_W'(1);

  always_comb begin
    pc_d         = pc_q;
    int_id_d     = int_id_q;
    int_active_d = int_active_q;
    sp_d         = sp_q;
    stack_d      = stack_q;
    clr          = '0;
    wb_d         = writeBack;
    if (writeBack && !wb_q) begin
      if (reti && (sp_q != '0)) begin
        pc_d         = PC_W'(top.pc);
        int_id_d     = ID_W'(top.id);
        sp_d         = sp_q - SP_W'(1);
        int_active_d = (sp_q != SP_W'(1));
      end else if (reti) begin
        pc_d = pc_q + PC_W'(1);
      end else if (win_vld && gate) begin
        stack_d[push_idx] = '{pc: STK_PC_W'(ret_pc), id: STK_ID_W'(int_id_q)};
        sp_d              = sp_q + SP_W'(1);
        pc_d              = PC_W'(VEC_BASE) + PC_W'(win);
        int_id_d          = win;
        int_active_d      = 1'b1;
        clr               = NUM_INT'(1) << win;
      end else begin
        pc_d = ret_pc;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      pc_q         <= PC_START;
      int_id_q     <= '0;
      int_active_q <= 1'b0;
      wb_q         <= 1'b0;
      sp_q         <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q         <= pc_d;
      int_id_q     <= int_id_d;
      int_active_q <= int_active_d;
      wb_q         <= wb_d;
      sp_q         <= sp_d;
      stack_q      <= stack_d;
    end
  end

  assign pc_out     = pc_q;
  assign int_id     = int_id_q;
  assign int_active = int_active_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_int_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pc_int_ctrl : directed scenarios plus random traffic against a queue model
// Rev 1.0
// ============================================================================
module tb_pc_int_ctrl;

  localparam int              PC_W     = 27;
  localparam int              NUM_INT  = 8;
  localparam int              ID_W     = 3;
  localparam int              VEC_BASE = 1;
  localparam int              NDEPTH   = 2;
  localparam logic [PC_W-1:0] PC_START = 27'hC02522;
`ifdef PC_INT_NEST_EN
  localparam bit NEST    = 1'b1;
  localparam int M_DEPTH = NDEPTH;
`else
  localparam bit NEST    = 1'b0;
  localparam int M_DEPTH = 1;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               writeBack = 1'b0, jump = 1'b0, offset = 1'b0, reti = 1'b0;
  logic               mask_we = 1'b0;
  logic [PC_W-1:0]    jump_addr = '0;
  logic [NUM_INT-1:0] int_in = '0, mask_wdata = '0;
  logic [PC_W-1:0]    pc_out;
  logic [ID_W-1:0]    int_id;
  logic               int_active;
  logic [NUM_INT-1:0] pending;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_int_ctrl #(
    .PC_W(PC_W), .PC_START(PC_START), .NUM_INT(NUM_INT),
    .VEC_BASE(VEC_BASE), .NEST_DEPTH(NDEPTH)
  ) dut (
    .clk(clk), .reset(reset), .writeBack(writeBack), .jump(jump), .offset(offset),
    .jump_addr(jump_addr), .reti(reti), .int_in(int_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .pc_out(pc_out), .int_id(int_id),
    .int_active(int_active), .pending(pending)
  );

  // Reference model: stack as queues, rules applied once per falling edge.
  logic [PC_W-1:0]    m_pc;
  int                 m_id;
  bit                 m_active;
  bit                 m_wb;
  logic [NUM_INT-1:0] m_pend, m_mask, m_s, m_prev;
  logic [PC_W-1:0]    q_pc[$];
  int                 q_id[$];

  always @(negedge clk) begin
    logic [NUM_INT-1:0] rise, clr;
    logic [PC_W-1:0]    ret;
    int                 win;
    bit                 gate;
    if (reset) begin
      m_pc = PC_START; m_id = 0; m_active = 0; m_wb = 0;
      m_pend = '0; m_mask = '1; m_s = '0; m_prev = '0;
      q_pc.delete(); q_id.delete();
    end else begin
      rise = m_s & ~m_prev;
      clr  = '0;
      if (writeBack && !m_wb) begin
        win = -1;
        if (m_pc < PC_START)
          for (int i = 0; i < NUM_INT; i++)
            if (win < 0 && m_pend[i] && m_mask[i]) win = i;
        if (NEST) gate = (q_pc.size() == 0) || (win < m_id && q_pc.size() < M_DEPTH);
        else      gate = !m_active;
        if (jump) ret = offset ? m_pc + jump_addr : jump_addr;
        else      ret = m_pc + PC_W'(1);
        if (reti && q_pc.size() > 0) begin
          m_pc = q_pc.pop_back();
          m_id = q_id.pop_back();
          if (q_pc.size() == 0) m_active = 0;
        end else if (reti) begin
          m_pc = m_pc + PC_W'(1);
        end else if (win >= 0 && gate) begin
          q_pc.push_back(ret);
          q_id.push_back(m_id);
          m_pc = PC_W'(VEC_BASE + win);
          m_id = win;
          m_active = 1;
          clr[win] = 1'b1;
        end else begin
          m_pc = ret;
        end
      end
      m_pend = (m_pend & ~clr) | rise;
      if (mask_we) m_mask = mask_wdata;
      m_prev = m_s;
      m_s    = int_in;
      m_wb   = writeBack;
    end
  end

  task automatic chk_model(input string tag);
    n_assert++;
    assert (pc_out === m_pc) else begin
      n_fail++; $error("FAIL %s pc_out observed=%h expected=%h", tag, pc_out, m_pc);
    end
    n_assert++;
    assert (int_id === ID_W'(m_id)) else begin
      n_fail++; $error("FAIL %s int_id observed=%0d expected=%0d", tag, int_id, m_id);
    end
    n_assert++;
    assert (int_active === m_active) else begin
      n_fail++; $error("FAIL %s int_active observed=%b expected=%b", tag, int_active, m_active);
    end
    n_assert++;
    assert (pending === m_pend) else begin
      n_fail++; $error("FAIL %s pending observed=%b expected=%b", tag, pending, m_pend);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic step(input bit r, input bit j, input bit off, input logic [PC_W-1:0] a);
    writeBack = 1'b1; reti = r; jump = j; offset = off; jump_addr = a;
    tick("step");
    tick("step_hold");
    writeBack = 1'b0; reti = 1'b0; jump = 1'b0; offset = 1'b0; jump_addr = '0;
    tick("step_low");
  endtask

  task automatic pulse(input logic [NUM_INT-1:0] b);
    int_in = int_in | b;
    tick("pulse_hi");
    int_in = int_in & ~b;
    tick("pulse_lo");
    tick("pulse_wait");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick("rst");
    tick("rst");
    reset = 1'b0;
    tick("rst_rel");
  endtask

  initial begin
    do_reset();
    chk_val("reset_pc", 32'(pc_out), 32'(27'hC02522));
    chk_val("reset_active", 32'(int_active), 32'd0);
    chk_val("reset_pending", 32'(pending), 32'd0);

    // Sequential stepping above PC_START: interrupts stay pending.
    pulse(8'h01);
    repeat (3) step(0, 0, 0, '0);
    chk_val("seq3_pc", 32'(pc_out), 32'(PC_START + PC_W'(3)));
    chk_val("seq3_no_accept", 32'(int_active), 32'd0);
    chk_val("seq3_pend0", 32'(pending[0]), 32'd1);

    // Absolute jump, vector to source 2, return.
    do_reset();
    step(0, 1, 0, 27'h100);
    chk_val("jump_abs", 32'(pc_out), 32'h100);
    pulse(8'h04);
    step(0, 0, 0, '0);
    chk_val("vec2_pc", 32'(pc_out), 32'd3);
    chk_val("vec2_id", 32'(int_id), 32'd2);
    step(1, 0, 0, '0);
    chk_val("reti_pc", 32'(pc_out), 32'h101);
    chk_val("reti_active", 32'(int_active), 32'd0);

    // Simultaneous sources 5 and 1: 1 first, 5 only after return.
    do_reset();
    step(0, 1, 0, 27'h100);
    pulse(8'h22);
    step(0, 0, 0, '0);
    chk_val("prio_pc", 32'(pc_out), 32'd2);
    chk_val("prio_id", 32'(int_id), 32'd1);
    step(0, 0, 0, '0);
    chk_val("no_preempt_pc", 32'(pc_out), 32'd3);
    step(1, 0, 0, '0);
    chk_val("prio_reti_pc", 32'(pc_out), 32'h101);
    step(0, 0, 0, '0);
    chk_val("second_src_pc", 32'(pc_out), 32'd6);
    chk_val("second_src_id", 32'(int_id), 32'd5);

    // Masked source latches but does not vector until re-enabled.
    do_reset();
    step(0, 1, 0, 27'h100);
    mask_we = 1'b1; mask_wdata = 8'hF7;
    tick("mask_wr");
    mask_we = 1'b0;
    pulse(8'h08);
    chk_val("masked_pend3", 32'(pending[3]), 32'd1);
    step(0, 0, 0, '0);
    chk_val("masked_pc", 32'(pc_out), 32'h101);
    mask_we = 1'b1; mask_wdata = 8'hFF;
    tick("mask_wr");
    mask_we = 1'b0;
    step(0, 0, 0, '0);
    chk_val("unmask_pc", 32'(pc_out), 32'd4);

    // Relative wrap, then reset during service.
    do_reset();
    step(0, 1, 0, 27'h10);
    step(0, 1, 1, '1);
    chk_val("wrap_pc", 32'(pc_out), 32'h0F);
    pulse(8'h40);
    step(0, 0, 0, '0);
    chk_val("svc6_pc", 32'(pc_out), 32'd7);
    reset = 1'b1;
    tick("mid_rst");
    chk_val("mid_rst_pc", 32'(pc_out), 32'(PC_START));
    chk_val("mid_rst_active", 32'(int_active), 32'd0);
    reset = 1'b0;
    tick("mid_rst_rel");

`ifdef PC_INT_NEST_EN
    do_reset();
    step(0, 1, 0, 27'h100);
    pulse(8'h10);
    step(0, 0, 0, '0);
    chk_val("nest_src4_pc", 32'(pc_out), 32'd5);
    pulse(8'h04);
    step(0, 0, 0, '0);
    chk_val("nest_preempt_pc", 32'(pc_out), 32'd3);
    pulse(8'h01);
    step(0, 0, 0, '0);
    chk_val("nest_full_pc", 32'(pc_out), 32'd4);
    chk_val("nest_full_pend0", 32'(pending[0]), 32'd1);
    step(1, 0, 0, '0);
    chk_val("nest_ret1_pc", 32'(pc_out), 32'd6);
    chk_val("nest_ret1_id", 32'(int_id), 32'd4);
    step(1, 0, 0, '0);
    chk_val("nest_ret2_pc", 32'(pc_out), 32'h101);
    chk_val("nest_ret2_active", 32'(int_active), 32'd0);
`endif

    // Random traffic checked every cycle against the model.
    do_reset();
    step(0, 1, 0, 27'h200);
    for (int n = 0; n < 600; n++) begin
      writeBack = 1'($urandom_range(0, 1));
      jump      = ($urandom_range(0, 3) == 0);
      offset    = 1'($urandom_range(0, 1));
      jump_addr = ($urandom_range(0, 7) == 0) ? PC_W'($urandom) : PC_W'($urandom_range(0, 'h3FF));
      reti      = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) int_in = NUM_INT'($urandom);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = NUM_INT'($urandom);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
